// File: rtl/cat_control_unit.sv
// Top-level sequencer for the chromatic-adaptation accelerator: schedules ALS reads,
// follows the processing/display pipeline status until idle, and drives a debug LED bank.
module cat_control_unit #(
   parameter int INIT_DELAY    = 16,
   parameter int REFRESH_DELAY = 10_000_000,
   parameter int ALS_TIMEOUT   = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       als_busy,
   input  logic       processing_busy,
   input  logic       display_busy,
   input  logic       cct_valid,
   input  logic       xyz_valid,
   input  logic       matrix_valid,
   input  logic [3:0] sw,
   output logic       als_read_req,
   output logic [7:0] leds
);

   typedef enum logic [1:0] {
      INIT     = 2'b00,
      READ_ALS = 2'b01,
      PROCESS  = 2'b10,
      WAIT     = 2'b11
   } state_t;

   localparam int IW = (INIT_DELAY > 0) ? $clog2(INIT_DELAY + 1) : 1;
   localparam int TW = (ALS_TIMEOUT > 1) ? $clog2(ALS_TIMEOUT + 1) : 1;
   localparam logic [23:0] REFRESH_24 = 24'(REFRESH_DELAY);

   state_t         state;
   logic [IW-1:0]  init_cnt;
   logic [TW-1:0]  timeout_cnt;
   logic [23:0]    delay_counter;
   logic           matrix_seen;
   logic [23:0]    period;
   logic           matrix_done;
   logic           pipeline_idle;

   always_comb begin
      period        = REFRESH_24 >> sw[3:2];
      matrix_done   = matrix_seen | matrix_valid;
      pipeline_idle = ~processing_busy & ~display_busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= INIT;
         als_read_req  <= 1'b0;
         leds          <= 8'd0;
         delay_counter <= 24'd0;
         matrix_seen   <= 1'b0;
         init_cnt      <= '0;
         timeout_cnt   <= '0;
      end else begin
         als_read_req <= 1'b0;
         leds <= {als_busy, cct_valid, xyz_valid, matrix_valid,
                  processing_busy, display_busy, state};
         case (state)
            INIT: begin
               if (init_cnt == IW'(INIT_DELAY)) begin
                  state        <= READ_ALS;
                  als_read_req <= 1'b1;
                  timeout_cnt  <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            READ_ALS: begin
               // A CCT arriving on the timeout cycle takes priority over a re-request.
               if (cct_valid) begin
                  state       <= PROCESS;
                  matrix_seen <= 1'b0;
               end else if (timeout_cnt == TW'(ALS_TIMEOUT - 1)) begin
                  als_read_req <= 1'b1;
                  timeout_cnt  <= '0;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            PROCESS: begin
               if (matrix_done && pipeline_idle) begin
                  state         <= WAIT;
                  delay_counter <= period;
               end else begin
                  matrix_seen <= matrix_done;
               end
            end
            WAIT: begin
               // Force-read beats both pause and the remaining delay.
               if (sw[1] || delay_counter == 24'd0) begin
                  state        <= READ_ALS;
                  als_read_req <= 1'b1;
                  timeout_cnt  <= '0;
               end else if (!sw[0]) begin
                  delay_counter <= delay_counter - 24'd1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_cat_control_unit.sv
// Randomized self-checking bench for cat_control_unit against an event/timestamp
// based reference model of the sequencer.
module tb_cat_control_unit;

   localparam int INIT_DELAY    = 4;
   localparam int REFRESH_DELAY = 200;
   localparam int ALS_TIMEOUT   = 50;

   localparam int P_INIT = 0, P_READ = 1, P_PROC = 2, P_WAIT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       als_busy = 1'b0, processing_busy = 1'b0, display_busy = 1'b0;
   logic       cct_valid = 1'b0, xyz_valid = 1'b0, matrix_valid = 1'b0;
   logic [3:0] sw = 4'd0;
   logic       als_read_req;
   logic [7:0] leds;

   cat_control_unit #(
      .INIT_DELAY   (INIT_DELAY),
      .REFRESH_DELAY(REFRESH_DELAY),
      .ALS_TIMEOUT  (ALS_TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .als_busy       (als_busy),
      .processing_busy(processing_busy),
      .display_busy   (display_busy),
      .cct_valid      (cct_valid),
      .xyz_valid      (xyz_valid),
      .matrix_valid   (matrix_valid),
      .sw             (sw),
      .als_read_req   (als_read_req),
      .leds           (leds)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Reference model: time is measured in clock edges since reset release;
   // INIT and READ_ALS behaviour is expressed as deadlines on those timestamps.
   int         m_phase;
   int         m_edges;
   int         m_last_req;
   int         m_remaining;
   bit         m_seen;
   bit         m_req;
   logic [7:0] m_leds;
   bit         prev_req;

   // Stimulus knobs (percentages)
   int  p_cct, p_mv, p_busy, p_xyz, p_pause, p_force, rate;
   bit  coincide;

   task automatic model_reset();
      m_phase = P_INIT; m_edges = 0; m_last_req = 0; m_remaining = 0;
      m_seen = 0; m_req = 0; m_leds = 8'd0; prev_req = 0;
   endtask

   task automatic issue_request();
      m_phase    = P_READ;
      m_req      = 1;
      m_last_req = m_edges;
   endtask

   task automatic model_edge();
      if (rst) return;
      m_edges++;
      m_leds = {als_busy, cct_valid, xyz_valid, matrix_valid,
                processing_busy, display_busy, 2'(m_phase)};
      m_req  = 0;
      case (m_phase)
         P_INIT: if (m_edges == INIT_DELAY + 1) issue_request();
         P_READ: begin
            if (cct_valid) begin
               m_phase = P_PROC;
               m_seen  = 0;
            end else if (m_edges - m_last_req == ALS_TIMEOUT) begin
               issue_request();
            end
         end
         P_PROC: begin
            m_seen = m_seen | matrix_valid;
            if (m_seen && !processing_busy && !display_busy) begin
               m_phase     = P_WAIT;
               m_remaining = REFRESH_DELAY / (1 << sw[3:2]);
            end
         end
         default: begin
            if (sw[1] || m_remaining == 0) issue_request();
            else if (!sw[0]) m_remaining--;
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("als_read_req", 32'(als_read_req), 32'(m_req));
      check("leds", 32'(leds), 32'(m_leds));
      if (m_phase == P_WAIT) check("delay_counter", 32'(dut.delay_counter), 32'(m_remaining));
      check("req_back_to_back", 32'(prev_req & als_read_req), 32'd0);
      prev_req = als_read_req;
   endtask

   function automatic logic chance(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic drive_inputs();
      bit timeout_next;
      timeout_next = (m_phase == P_READ) && (m_edges + 1 - m_last_req == ALS_TIMEOUT);
      if (coincide && timeout_next) cct_valid = 1'b1;
      else cct_valid = !cct_valid && chance(p_cct);
      matrix_valid    = chance(p_mv);
      xyz_valid       = chance(p_xyz);
      als_busy        = chance(p_busy);
      processing_busy = chance(p_busy);
      display_busy    = chance(p_busy);
      sw = {2'(rate), chance(p_force), chance(p_pause)};
   endtask

   task automatic set_knobs(input int cct, input int mv, input int busy, input int xyz,
                            input int pause, input int force_pct, input int r, input bit co);
      p_cct = cct; p_mv = mv; p_busy = busy; p_xyz = xyz;
      p_pause = pause; p_force = force_pct; rate = r; coincide = co;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive_inputs();
         tick();
      end
   endtask

   initial begin
      bit reached;
      model_reset();
      set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
      drive_inputs();
      for (int i = 0; i < 3; i++) tick();

      rst = 1'b0;
      run(120);                                  // INIT, first request, repeated timeouts

      set_knobs(3, 10, 40, 20, 0, 0, 0, 0);
      run(2000);                                 // general pipeline traffic

      for (int r = 0; r < 4; r++) begin
         set_knobs(4, 15, 35, 20, 20, 1, r, 0);
         run(1500);                              // every refresh rate with pause/force
      end

      set_knobs(0, 20, 30, 10, 0, 0, 1, 1);
      run(1500);                                 // CCT landing exactly on the timeout

      // Reset in the middle of PROCESS
      set_knobs(50, 0, 100, 0, 0, 0, 0, 0);
      reached = 0;
      for (int i = 0; i < 3000 && !reached; i++) begin
         drive_inputs();
         tick();
         reached = (m_phase == P_PROC);
      end
      check("reached_process", 32'(reached), 32'd1);
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_req", 32'(als_read_req), 32'd0);
      check("async_rst_leds", 32'(leds), 32'd0);
      @(negedge clk);
      set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
      drive_inputs();
      tick();
      tick();
      rst = 1'b0;
      run(70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
